// File: rtl/control_pkg.sv
// Encodings shared by the control FSM and data_path: y update ops, s step
// codes and the step-value lookup.
package control_pkg;

  typedef enum logic [1:0] {
    Y_HOLD = 2'b00,
    Y_INC  = 2'b01,
    Y_DEC  = 2'b10,
    Y_ROL  = 2'b11
  } y_sel_e;

  typedef enum logic [1:0] {
    STEP_0 = 2'b00,
    STEP_2 = 2'b01,
    STEP_4 = 2'b10,
    STEP_6 = 2'b11
  } step_e;

  localparam int unsigned STEP_W = 3;

  localparam logic [STEP_W-1:0] STEP_0_VAL = 3'd0;
  localparam logic [STEP_W-1:0] STEP_2_VAL = 3'd2;
  localparam logic [STEP_W-1:0] STEP_4_VAL = 3'd4;
  localparam logic [STEP_W-1:0] STEP_6_VAL = 3'd6;

  function automatic logic [STEP_W-1:0] step_value(input step_e st);
    logic [STEP_W-1:0] v;
    v = STEP_0_VAL;
    case (st)
      STEP_0:  v = STEP_0_VAL;
      STEP_2:  v = STEP_2_VAL;
      STEP_4:  v = STEP_4_VAL;
      STEP_6:  v = STEP_6_VAL;
      default: v = STEP_0_VAL;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/data_path_s_accum.sv
// s_accum: SW-wide step accumulator with clear priority and sticky ovf.
// Wraps modulo 2**SW by default; DATA_PATH_SAT_EN makes it saturate instead.
module s_accum #(
  parameter int unsigned SW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    step,
  input  logic          en,
  input  logic          add,
  input  logic          clr,
  output logic [SW-1:0] s,
  output logic [SW-1:0] s_next,
  output logic          ovf
);
  import control_pkg::*;

  logic [SW:0] step_ext;
  logic [SW:0] sum;
  logic [SW:0] diff;
  logic        wrap_evt;
  logic        ovf_next;

  assign step_ext = (SW+1)'(step_value(step_e'(step)));
  assign sum      = {1'b0, s} + step_ext;
  assign diff     = {1'b0, s} - step_ext;

  always_comb begin
    s_next   = s;
    ovf_next = ovf;
    wrap_evt = 1'b0;
    if (clr) begin
      s_next   = '0;
      ovf_next = 1'b0;
    end else if (en) begin
      // Extra MSB holds add carry-out / subtract borrow; step 0 can produce neither.
      s_next   = add ? sum[SW-1:0] : diff[SW-1:0];
      wrap_evt = add ? sum[SW] : diff[SW];
      if (wrap_evt) begin
        ovf_next = 1'b1;
`ifdef DATA_PATH_SAT_EN
        s_next   = add ? '1 : '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s   <= '0;
      ovf <= 1'b0;
    end else begin
      s   <= s_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: rtl/data_path.sv
// data_path: y register, s accumulator and registered status flags driven by
// the control FSM strobes. Build with DATA_PATH_SAT_EN for saturating s.
module data_path #(
  parameter int unsigned W       = 8,
  parameter int unsigned SW      = 6,
  parameter int unsigned S_LIMIT = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  x,
  input  logic          active,
  input  logic [1:0]    y_select_next,
  input  logic [1:0]    s_step,
  input  logic          y_en,
  input  logic          s_en,
  input  logic          y_store_x,
  input  logic          s_add,
  input  logic          s_zero,
  output logic [W-1:0]  y,
  output logic [SW-1:0] s,
  output logic          s_is_zero,
  output logic          s_ge_limit,
  output logic          y_eq_x,
  output logic          ovf
);
  import control_pkg::*;

  localparam logic [SW-1:0] LIMIT = SW'(S_LIMIT);

  logic          y_en_eff;
  logic          s_en_eff;
  logic          s_zero_eff;
  logic [W-1:0]  y_next;
  logic [SW-1:0] s_next;

  assign y_en_eff   = y_en & active;
  assign s_en_eff   = s_en & active;
  assign s_zero_eff = s_zero & active;

  always_comb begin
    y_next = y;
    if (y_en_eff) begin
      if (y_store_x) begin
        y_next = x;
      end else begin
        case (y_sel_e'(y_select_next))
          Y_HOLD:  y_next = y;
          Y_INC:   y_next = y + 1'b1;
          Y_DEC:   y_next = y - 1'b1;
          Y_ROL:   y_next = {y[W-2:0], y[W-1]};
          default: y_next = y;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y <= '0;
    end else begin
      y <= y_next;
    end
  end

  s_accum #(
    .SW(SW)
  ) u_s_accum (
    .clk    (clk),
    .rst    (rst),
    .step   (s_step),
    .en     (s_en_eff),
    .add    (s_add),
    .clr    (s_zero_eff),
    .s      (s),
    .s_next (s_next),
    .ovf    (ovf)
  );

  // Flags are built from next-state values so they line up with the new y/s.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_is_zero  <= 1'b1;
      s_ge_limit <= 1'b0;
      y_eq_x     <= 1'b0;
    end else begin
      s_is_zero  <= (s_next == '0);
      s_ge_limit <= (s_next >= LIMIT);
      y_eq_x     <= (y_next == x);
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: stimulus queues hand-computed expectations,
// a monitor pops and compares after each clock edge or async reset.
module tb_data_path;
  import control_pkg::*;

`ifdef DATA_PATH_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] x;
  logic       active;
  logic [1:0] y_select_next;
  logic [1:0] s_step;
  logic       y_en;
  logic       s_en;
  logic       y_store_x;
  logic       s_add;
  logic       s_zero;
  logic [7:0] y;
  logic [5:0] s;
  logic       s_is_zero;
  logic       s_ge_limit;
  logic       y_eq_x;
  logic       ovf;

  data_path #(
    .W(8),
    .SW(6),
    .S_LIMIT(48)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .x             (x),
    .active        (active),
    .y_select_next (y_select_next),
    .s_step        (s_step),
    .y_en          (y_en),
    .s_en          (s_en),
    .y_store_x     (y_store_x),
    .s_add         (s_add),
    .s_zero        (s_zero),
    .y             (y),
    .s             (s),
    .s_is_zero     (s_is_zero),
    .s_ge_limit    (s_ge_limit),
    .y_eq_x        (y_eq_x),
    .ovf           (ovf)
  );

  typedef struct {
    int         id;
    logic [7:0] y;
    logic [5:0] s;
    logic       z;
    logic       ge;
    logic       yeq;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   bad    = 0;
  int   vec_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, id, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("y",          e.id, 32'(y),          32'(e.y));
        chk("s",          e.id, 32'(s),          32'(e.s));
        chk("s_is_zero",  e.id, 32'(s_is_zero),  32'(e.z));
        chk("s_ge_limit", e.id, 32'(s_ge_limit), 32'(e.ge));
        chk("y_eq_x",     e.id, 32'(y_eq_x),     32'(e.yeq));
        chk("ovf",        e.id, 32'(ovf),        32'(e.ovf));
      end
    end
  end

  task automatic idle_inputs(input logic [7:0] xv);
    x = xv; active = 1'b1; y_en = 1'b0; y_store_x = 1'b0; y_select_next = Y_HOLD;
    s_en = 1'b0; s_add = 1'b0; s_step = STEP_0; s_zero = 1'b0;
  endtask

  task automatic go(input logic [7:0] xv, input logic act, input logic yen, input logic ystx,
                    input logic [1:0] ysel, input logic sen, input logic sadd,
                    input logic [1:0] stp, input logic szr,
                    input logic [7:0] ey, input logic [5:0] es, input logic ez,
                    input logic ege, input logic eyq, input logic eov);
    @(negedge clk);
    x = xv; active = act; y_en = yen; y_store_x = ystx; y_select_next = ysel;
    s_en = sen; s_add = sadd; s_step = stp; s_zero = szr;
    vec_id++;
    q.push_back('{vec_id, ey, es, ez, ege, eyq, eov});
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    idle_inputs(8'h11);
    #2;
    vec_id++;
    q.push_back('{vec_id, 8'h00, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs(8'h11);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // reset state seen through an idle cycle
    go(8'h11, 1, 0, 0, Y_HOLD, 0, 0, STEP_0, 0, 8'h00, 6'd0, 1, 0, 0, 0);
    // y path
    go(8'h81, 1, 1, 1, Y_HOLD, 0, 0, STEP_0, 0, 8'h81, 6'd0, 1, 0, 1, 0);
    go(8'h81, 1, 1, 0, Y_ROL,  0, 0, STEP_0, 0, 8'h03, 6'd0, 1, 0, 0, 0);
    go(8'h81, 1, 1, 0, Y_DEC,  0, 0, STEP_0, 0, 8'h02, 6'd0, 1, 0, 0, 0);
    go(8'hFF, 1, 1, 1, Y_HOLD, 0, 0, STEP_0, 0, 8'hFF, 6'd0, 1, 0, 1, 0);
    go(8'hFF, 1, 1, 0, Y_INC,  0, 0, STEP_0, 0, 8'h00, 6'd0, 1, 0, 0, 0);
    // s accumulate up then down
    go(8'h11, 1, 0, 0, Y_HOLD, 1, 1, STEP_6, 0, 8'h00, 6'd6,  0, 0, 0, 0);
    go(8'h11, 1, 0, 0, Y_HOLD, 1, 1, STEP_4, 0, 8'h00, 6'd10, 0, 0, 0, 0);
    go(8'h11, 1, 0, 0, Y_HOLD, 1, 1, STEP_2, 0, 8'h00, 6'd12, 0, 0, 0, 0);
    go(8'h11, 1, 0, 0, Y_HOLD, 1, 1, STEP_0, 0, 8'h00, 6'd12, 0, 0, 0, 0);
    go(8'h11, 1, 0, 0, Y_HOLD, 1, 0, STEP_6, 0, 8'h00, 6'd6,  0, 0, 0, 0);
    go(8'h11, 1, 0, 0, Y_HOLD, 1, 0, STEP_6, 0, 8'h00, 6'd0,  1, 0, 0, 0);
    // limit flag rises exactly at 48
    for (int k = 1; k <= 8; k++)
      go(8'h11, 1, 0, 0, Y_HOLD, 1, 1, STEP_6, 0, 8'h00, 6'(6*k), 0, (6*k >= 48), 0, 0);
    go(8'h11, 1, 0, 0, Y_HOLD, 1, 1, STEP_6, 0, 8'h00, 6'd54, 0, 1, 0, 0);
    go(8'h11, 1, 0, 0, Y_HOLD, 1, 1, STEP_6, 0, 8'h00, 6'd60, 0, 1, 0, 0);
    go(8'h11, 1, 0, 0, Y_HOLD, 1, 1, STEP_2, 0, 8'h00, 6'd62, 0, 1, 0, 0);
    // add overflow: wrap to 2 or clamp at 63
    go(8'h11, 1, 0, 0, Y_HOLD, 1, 1, STEP_4, 0, 8'h00, SAT ? 6'd63 : 6'd2, 0, SAT, 0, 1);
    // clear beats add and drops ovf
    go(8'h11, 1, 0, 0, Y_HOLD, 1, 1, STEP_6, 1, 8'h00, 6'd0, 1, 0, 0, 0);
    // subtract underflow: wrap to 62 or clamp at 0
    go(8'h11, 1, 0, 0, Y_HOLD, 1, 0, STEP_2, 0, 8'h00, SAT ? 6'd0 : 6'd62, SAT, !SAT, 0, 1);
    // inactive: every enable ignored
    go(8'h22, 0, 1, 1, Y_INC,  1, 1, STEP_6, 1, 8'h00, SAT ? 6'd0 : 6'd62, SAT, !SAT, 0, 1);
    go(8'h11, 1, 0, 0, Y_HOLD, 0, 0, STEP_0, 1, 8'h00, 6'd0, 1, 0, 0, 0);
    // step 0 subtract at s=0 must not flag overflow
    go(8'h11, 1, 0, 0, Y_HOLD, 1, 0, STEP_0, 0, 8'h00, 6'd0, 1, 0, 0, 0);
    // y and s in the same cycle
    go(8'h01, 1, 1, 0, Y_INC,  1, 1, STEP_4, 0, 8'h01, 6'd4,  0, 0, 1, 0);
    go(8'h5A, 1, 1, 1, Y_HOLD, 1, 1, STEP_6, 0, 8'h5A, 6'd10, 0, 0, 1, 0);
    go(8'h5A, 1, 0, 0, Y_HOLD, 1, 0, STEP_6, 0, 8'h5A, 6'd4,  0, 0, 1, 0);
    go(8'h5A, 1, 0, 0, Y_HOLD, 1, 0, STEP_6, 0, 8'h5A, SAT ? 6'd0 : 6'd62, SAT, !SAT, 1, 1);
    // async reset mid-cycle
    reset_pulse();
    go(8'h11, 1, 0, 0, Y_HOLD, 0, 0, STEP_0, 0, 8'h00, 6'd0, 1, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- Datapath counterpart of the control FSM: consumes the FSM's control strobes (y_select_next, s_step, y_en, s_en, y_store_x, s_add, s_zero, active).
- Owns two registers:
  - y: a data/selection register loaded from the external input x or updated in place.
  - s: a step accumulator that moves by 0/2/4/6.
- Returns registered status flags to the control FSM for its transition decisions.

Parameters:
- W, 8, width of x and y.
- SW, 6, width of accumulator s (unsigned).
- S_LIMIT, 48, compare threshold for s_ge_limit; must be < 2**SW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- x  in  W  external operand, sampled only when y is loaded from x.
- active  in  1  from FSM; when 0, all enables are ignored (registers hold).
- y_select_next  in  2  y update op: 00 hold, 01 y+1, 10 y-1, 11 rotate-left-1.
- s_step  in  2  step size: 00->0, 01->2, 10->4, 11->6.
- y_en  in  1  y update enable.
- s_en  in  1  s update enable.
- y_store_x  in  1  when y_en=1, load x (overrides y_select_next).
- s_add  in  1  1: s+=step, 0: s-=step.
- s_zero  in  1  synchronous clear of s (overrides s_en/s_add).
- y  out  W  y register.
- s  out  SW  accumulator.
- s_is_zero  out  1  registered flag, s==0.
- s_ge_limit  out  1  registered flag, s>=S_LIMIT.
- y_eq_x  out  1  registered flag, y==x.
- ovf  out  1  sticky: any wrap/saturation event on s since last s_zero or reset.

Behaviour:
- Reset (rst=0, async): y=0, s=0, s_is_zero=1, s_ge_limit=0, y_eq_x=0, ovf=0. Registers update on the first clk edge after rst deasserts.
- Gating: effective enables are y_en&active, s_en&active, s_zero&active.
- y update, per edge, in priority order:
  - !y_en_eff: hold.
  - y_store_x: y<=x.
  - else per y_select_next.
  - +1/-1 wrap modulo 2**W; rotate moves MSB into LSB.
- s update, per edge, in priority order:
  - s_zero_eff: s<=0, ovf<=0.
  - else s_en_eff: s<=s±step, where step is zero-extended to SW.
  - else hold.
- Wrap (macro undefined):
  - Add carry-out or subtract borrow: s wraps modulo 2**SW and ovf<=1.
  - step=0 never sets ovf.
- Flags are registered and computed from the NEXT values of y/s, so they are valid in the same cycle as the new y/s (zero added latency relative to the registers). y_eq_x compares next-y with the current x.
- Simultaneous s_zero and s_en: clear wins.
- y and s operations are independent and may occur in the same cycle.
- Async reset mid-operation: all state is discarded immediately, no partial update.
- No handshake: the FSM is the sole master; every strobe is single-cycle qualified by the clk edge.

Optional Feature:
- Macro DATA_PATH_SAT_EN.
- When defined:
  - s saturates instead of wrapping: add clamps at 2**SW-1, subtract clamps at 0.
  - ovf is set on any clamp event.
- When undefined: modulo wrap as described above.
- The y path is unaffected either way.

Decomposition:
- Shared package (control_pkg), also used by the control FSM:
  - y_select_next encodings (Y_HOLD, Y_INC, Y_DEC, Y_ROL).
  - s_step encodings (STEP_0, STEP_2, STEP_4, STEP_6).
  - Step-value lookup constants.
- One sub-module, s_accum: SW-wide add/sub-by-step with wrap/saturate, ovf generation, and clear priority. The y register and flags stay in data_path.

Test Plan:
- Reset values: assert rst=0 mid-cycle with y=0x5A, s=10 -> y=0, s=0, s_is_zero=1, ovf=0 immediately, without waiting for clk.
- y ops: y_en=1, active=1, y_store_x=1, x=0x81 -> y=0x81, y_eq_x=1. Then Y_ROL -> 0x03; Y_DEC -> 0x02; Y_INC from 0xFF -> 0x00.
- s accumulate: s_add=1 with steps 6,4,2,0 from 0 -> 6, 10, 12, 12. Then s_add=0 step 6 twice -> 6, 0, and s_is_zero=1 on that edge.
- Wrap vs saturate (SW=6): s=62, add step 4 -> s=2, ovf=1 (no macro); s=63, ovf=1 (DATA_PATH_SAT_EN). s=1, sub step 2 -> 63 / 0, ovf=1.
- Priority/gating:
  - s_zero=1 with s_en=1, s_add=1, step 6 -> s=0, ovf cleared.
  - active=0 with y_en=s_en=s_zero=1 -> y, s, ovf unchanged.
- Limit flag: S_LIMIT=48, add step 6 eight times from 0 -> s_ge_limit rises exactly on the edge where s becomes 48.
